// File: rtl/audio_voice_sched_pkg.sv
// Shared types and register map for the multi-voice sample scheduler.
package audio_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACC,
    OUT
  } state_t;

  localparam logic [1:0] REG_BASE = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_CMD  = 2'd2;
  localparam logic [1:0] REG_IRQ  = 2'd3;

  localparam int CMD_VOICE_LSB = 0;
  localparam int CMD_VOICE_MSB = 1;
  localparam int CMD_START     = 2;
  localparam int CMD_STOP      = 3;
  localparam int CMD_LOOP      = 4;
  localparam int CMD_BASE_HI   = 8;
  localparam int IRQ_CLEAR     = 15;

endpackage

// File: rtl/audio_voice_sched_if.sv
// CPU register bus into the scheduler, with the level interrupt back out.
interface audio_voice_sched_if;
  logic        chipselect;
  logic        write;
  logic [1:0]  address;
  logic [15:0] writedata;
  logic        irq;

  modport master (output chipselect, output write, output address, output writedata, input irq);
  modport slave  (input chipselect, input write, input address, input writedata, output irq);
endinterface

// File: rtl/audio_voice_sched_voice.sv
// One playback voice: base/length/position/loop/active, with start/stop
// commands taking priority over the scheduler's position advance.
module audio_voice #(
  parameter int ADDR_W = 17,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              load_loop,
  input  logic              stop,
  input  logic              advance,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              active,
  output logic              done
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  pos_q, pos_d;
  logic              loop_q, loop_d;
  logic              active_q, active_d;
  logic              last;

  assign last    = ((LEN_W+1)'(pos_q) + (LEN_W+1)'(1)) == (LEN_W+1)'(len_q);
  assign rd_addr = base_q + ADDR_W'(pos_q);
  assign active  = active_q;

  // Next voice state: stop beats start, and any command beats the advance.
  always_comb begin
    base_d   = base_q;
    len_d    = len_q;
    pos_d    = pos_q;
    loop_d   = loop_q;
    active_d = active_q;
    done     = 1'b0;
    if (stop) begin
      active_d = 1'b0;
    end else if (load) begin
      base_d   = load_base;
      len_d    = load_len;
      loop_d   = load_loop;
      pos_d    = '0;
      active_d = 1'b1;
    end else if (advance && active_q) begin
      if (last) begin
        pos_d = '0;
        if (!loop_q) begin
          pos_d    = pos_q;
          active_d = 1'b0;
          done     = 1'b1;
        end
      end else begin
        pos_d = pos_q + LEN_W'(1);
      end
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_q   <= '0;
      len_q    <= '0;
      pos_q    <= '0;
      loop_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      base_q   <= base_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      loop_q   <= loop_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/audio_voice_sched.sv
// Time-slotted voice scheduler: one ROM read per voice per codec request,
// saturating mix, register-bus voice control and done interrupt.
module audio_voice_sched
  import audio_sched_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 2
) (
  input  logic               clk,
  input  logic               resetn,
  audio_voice_sched_if.slave bus,
  input  logic               sample_req,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_q
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int ACC_W   = DATA_W + VOICE_W;
  localparam logic [3:0] WAIT_LAST = 4'(ROM_LAT - 2);
  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

  state_t              state_q, state_d;
  logic [VOICE_W-1:0]  v_q, v_d;
  logic [3:0]          wait_q, wait_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                req_pend_q, req_pend_d;
  logic [DATA_W-1:0]   sample_out_q, sample_out_d;
  logic                sample_valid_q, sample_valid_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]         staged_base_q, staged_base_d;
  logic [15:0]         staged_len_q, staged_len_d;
  logic [NUM_VOICES-1:0] done_pend_q, done_pend_d;
  logic [NUM_VOICES-1:0] irq_en_q, irq_en_d;
  logic                irq_q, irq_d;

  logic                  reg_wr;
  logic                  cmd_wr;
  logic                  cmd_hit;
  logic [NUM_VOICES-1:0] voice_load, voice_stop, voice_adv, voice_active, voice_done;
  logic [ADDR_W-1:0]     voice_addr [NUM_VOICES];
  logic [ADDR_W-1:0]     load_base;
  logic [ACC_W-1:0]      rom_ext;

  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] a);
    logic [ACC_W-DATA_W:0] hi;
    hi = a[ACC_W-1:DATA_W-1];
    if (hi == '0 || hi == '1) return a[DATA_W-1:0];
    else if (a[ACC_W-1]) return {1'b1, {(DATA_W-1){1'b0}}};
    else return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  assign reg_wr    = bus.chipselect && bus.write;
  assign cmd_wr    = reg_wr && (bus.address == REG_CMD);
  assign load_base = ADDR_W'({bus.writedata[CMD_BASE_HI], staged_base_q});
  assign rom_ext   = {{(ACC_W-DATA_W){rom_q[DATA_W-1]}}, rom_q};

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign rom_addr     = rom_addr_q;
  assign bus.irq      = irq_q;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    audio_voice #(.ADDR_W(ADDR_W), .LEN_W(16)) u_voice (
      .clk       (clk),
      .resetn    (resetn),
      .load      (voice_load[i]),
      .load_base (load_base),
      .load_len  (staged_len_q),
      .load_loop (bus.writedata[CMD_LOOP]),
      .stop      (voice_stop[i]),
      .advance   (voice_adv[i]),
      .rd_addr   (voice_addr[i]),
      .active    (voice_active[i]),
      .done      (voice_done[i])
    );
  end

  // Per-voice command decode and the advance strobe for the voice in its ACC slot.
  always_comb begin
    voice_load = '0;
    voice_stop = '0;
    voice_adv  = '0;
    cmd_hit    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cmd_hit       = cmd_wr && (int'(bus.writedata[CMD_VOICE_MSB:CMD_VOICE_LSB]) == i);
      voice_stop[i] = cmd_hit && bus.writedata[CMD_STOP];
      voice_load[i] = cmd_hit && bus.writedata[CMD_START] && !bus.writedata[CMD_STOP]
                      && (staged_len_q != '0);
      voice_adv[i]  = (state_q == ACC) && (int'(v_q) == i);
    end
  end

  // Staging, interrupt-enable and done-pending registers; a clear loses to a same-cycle done.
  always_comb begin
    staged_base_d = staged_base_q;
    staged_len_d  = staged_len_q;
    irq_en_d      = irq_en_q;
    done_pend_d   = done_pend_q;
    if (reg_wr) begin
      case (bus.address)
        REG_BASE: staged_base_d = bus.writedata;
        REG_LEN:  staged_len_d  = bus.writedata;
        REG_IRQ: begin
          irq_en_d = bus.writedata[NUM_VOICES-1:0];
          if (bus.writedata[IRQ_CLEAR]) done_pend_d = '0;
        end
        default: ;
      endcase
    end
    done_pend_d = done_pend_d | voice_done;
    irq_d       = |(done_pend_q & irq_en_q);
  end

  // Frame sequencer: issue, wait out ROM latency, accumulate, then saturate and publish.
  always_comb begin
    state_d        = state_q;
    v_d            = v_q;
    wait_d         = wait_q;
    acc_d          = acc_q;
    req_pend_d     = req_pend_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    rom_addr_d     = rom_addr_q;
    case (state_q)
      IDLE: begin
        if (sample_req || req_pend_q) begin
          state_d    = ISSUE;
          v_d        = '0;
          acc_d      = '0;
          req_pend_d = 1'b0;
        end
      end
      ISSUE: begin
        rom_addr_d = voice_addr[v_q];
        wait_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ACC;
        else wait_d = wait_q + 4'd1;
      end
      ACC: begin
        if (voice_active[v_q]) acc_d = acc_q + rom_ext;
        if (v_q == LAST_VOICE) begin
          state_d = OUT;
        end else begin
          v_d     = v_q + VOICE_W'(1);
          state_d = ISSUE;
        end
      end
      OUT: begin
        sample_out_d   = saturate(acc_q);
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && sample_req) req_pend_d = 1'b1;
  end

  // All scheduler state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      v_q            <= '0;
      wait_q         <= '0;
      acc_q          <= '0;
      req_pend_q     <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      rom_addr_q     <= '0;
      staged_base_q  <= '0;
      staged_len_q   <= '0;
      done_pend_q    <= '0;
      irq_en_q       <= '0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      v_q            <= v_d;
      wait_q         <= wait_d;
      acc_q          <= acc_d;
      req_pend_q     <= req_pend_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      rom_addr_q     <= rom_addr_d;
      staged_base_q  <= staged_base_d;
      staged_len_q   <= staged_len_d;
      done_pend_q    <= done_pend_d;
      irq_en_q       <= irq_en_d;
      irq_q          <= irq_d;
    end
  end

endmodule
